// File: rtl/cnn_3_3_sched.sv
// Job scheduler for a 3x3 convolution datapath: issues windows under FIFO credit, tracks results by tag, buffers them FWFT.
// Optional feature macro: CNN_SCHED_PERF_EN adds the perf_stall cycle counter port.
module cnn_3_3_sched #(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 9,
    parameter int PIPE_LAT    = 9,
    parameter int FIFO_DEPTH  = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              start,
    input  logic [CNT_WIDTH-1:0]              win_count,
    input  logic [31:0]                       cfg_bias,
    input  logic [31:0]                       cfg_scale,
    input  logic [7:0]                        cfg_shift,
    output logic                              busy,
    output logic                              done,
    input  logic                              win_valid,
    output logic                              win_ready,
    input  logic [DATA_WIDTH*KERNEL_SIZE-1:0] win_feature,
    input  logic [DATA_WIDTH*KERNEL_SIZE-1:0] win_weight,
    output logic [DATA_WIDTH*KERNEL_SIZE-1:0] dp_feature,
    output logic [DATA_WIDTH*KERNEL_SIZE-1:0] dp_weight,
    output logic [31:0]                       dp_bias,
    output logic [31:0]                       dp_scale,
    output logic [7:0]                        dp_shift,
    input  logic [DATA_WIDTH-1:0]             dp_result,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [DATA_WIDTH-1:0]             res_data,
`ifdef CNN_SCHED_PERF_EN
    output logic [31:0]                       perf_stall,
`endif
    output logic                              res_last
);

    localparam int KW  = DATA_WIDTH * KERNEL_SIZE;
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCW = AW + 1;
    localparam int IFW = $clog2(PIPE_LAT + 2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, issued_q, pushed_q;
    logic [31:0]          bias_q, scale_q;
    logic [7:0]           shift_q;
    logic [KW-1:0]        feat_q, wght_q;
    logic [PIPE_LAT:0]    tag_q;
    logic [IFW-1:0]       inflight_q;
    logic [FCW-1:0]       fcnt_q;
    logic [AW-1:0]        rd_ptr_q, wr_ptr_q;
    logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
    logic                 mem_last_q [FIFO_DEPTH];

    logic job_start, issue, capture, pop, credit_ok, last_issue, push_last;

    assign job_start  = (state_q == S_IDLE) && start;
    assign issue      = win_valid && win_ready;
    assign capture    = tag_q[PIPE_LAT];
    assign pop        = res_valid && res_ready;
    // Credits cover results still in the datapath, so a capture always finds room.
    assign credit_ok  = (32'(inflight_q) + 32'(fcnt_q)) < 32'(FIFO_DEPTH);
    assign win_ready  = (state_q == S_RUN) && (issued_q < cnt_q) && credit_ok;
    assign last_issue = issue && (issued_q == cnt_q - CNT_WIDTH'(1));
    assign push_last  = (pushed_q == cnt_q - CNT_WIDTH'(1));

    assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done       = (state_q == S_DONE);
    assign res_valid  = (fcnt_q != '0);
    assign res_data   = res_valid ? mem_data_q[rd_ptr_q] : '0;
    assign res_last   = res_valid && mem_last_q[rd_ptr_q];

    assign dp_feature = feat_q;
    assign dp_weight  = wght_q;
    assign dp_bias    = bias_q;
    assign dp_scale   = scale_q;
    assign dp_shift   = shift_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (win_count != '0) ? S_RUN : S_DONE;
            S_RUN:   if (last_issue) state_d = S_DRAIN;
            S_DRAIN: if (pop && res_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            issued_q   <= '0;
            pushed_q   <= '0;
            bias_q     <= '0;
            scale_q    <= '0;
            shift_q    <= '0;
            feat_q     <= '0;
            wght_q     <= '0;
            tag_q      <= '0;
            inflight_q <= '0;
            fcnt_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (job_start) begin
                cnt_q    <= win_count;
                bias_q   <= cfg_bias;
                scale_q  <= cfg_scale;
                shift_q  <= cfg_shift;
                issued_q <= '0;
                pushed_q <= '0;
            end else begin
                if (issue)   issued_q <= issued_q + CNT_WIDTH'(1);
                if (capture) pushed_q <= pushed_q + CNT_WIDTH'(1);
            end

            if (issue) begin
                feat_q <= win_feature;
                wght_q <= win_weight;
            end

            tag_q <= {tag_q[PIPE_LAT-1:0], issue};
            case ({issue, capture})
                2'b10:   inflight_q <= inflight_q + IFW'(1);
                2'b01:   inflight_q <= inflight_q - IFW'(1);
                default: ;
            endcase

            if (capture) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({capture, pop})
                2'b10:   fcnt_q <= fcnt_q + FCW'(1);
                2'b01:   fcnt_q <= fcnt_q - FCW'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: occupancy gates every visible output.
    always_ff @(posedge CLK) begin
        if (capture) begin
            mem_data_q[wr_ptr_q] <= dp_result;
            mem_last_q[wr_ptr_q] <= push_last;
        end
    end

`ifdef CNN_SCHED_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge CLK) begin
        if (RST || job_start) begin
            perf_q <= '0;
        end else if ((state_q == S_RUN) && win_valid && !win_ready && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall = perf_q;
`endif

endmodule

// File: doc/cnn_3_3_sched.md
CNN_3_3_SCHED -- requirements
Module: cnn_3_3_sched

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- DATA_WIDTH, 8, element width.
- KERNEL_SIZE, 9, elements per window.
- PIPE_LAT, 9, register stages in the 3x3 conv datapath from dp_feature/dp_weight to dp_result.
- FIFO_DEPTH, 16, result buffer entries (power of two, >= 2).
- CNT_WIDTH, 16, window counter width.

REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- CLK, in, 1, single clock; all logic on rising edge.
- RST, in, 1, synchronous, active-high reset.
- start, in, 1, job start pulse.
- win_count, in, CNT_WIDTH, windows in job.
- cfg_bias, in, 32, bias.
- cfg_scale, in, 32, scale.
- cfg_shift, in, 8, shift.
- busy, out, 1, job active.
- done, out, 1, one-cycle job-complete pulse.
- win_valid, in, 1, input window valid.
- win_ready, out, 1, input window accepted when both high.
- win_feature, in, DATA_WIDTH*KERNEL_SIZE, packed features.
- win_weight, in, DATA_WIDTH*KERNEL_SIZE, packed weights.
- dp_feature, out, DATA_WIDTH*KERNEL_SIZE, to datapath.
- dp_weight, out, DATA_WIDTH*KERNEL_SIZE, to datapath.
- dp_bias, out, 32, to datapath.
- dp_scale, out, 32, to datapath.
- dp_shift, out, 8, to datapath.
- dp_result, in, DATA_WIDTH, datapath output.
- res_valid, out, 1, result valid.
- res_ready, in, 1, result consumer ready.
- res_data, out, DATA_WIDTH, result.
- res_last, out, 1, final result of job.

Function
REQ-003 FSM SHALL have states IDLE, RUN, DRAIN, DONE.
REQ-004 IDLE: start=1 with win_count>0 SHALL go to RUN; start=1 with win_count=0 SHALL go to DONE; cfg_* and win_count latched on that edge.
REQ-005 start while not IDLE SHALL be ignored; latched config SHALL not change mid-job.
REQ-006 dp_bias/dp_scale/dp_shift SHALL be driven from latched config registers, stable for the entire job.
REQ-007 Issue = win_valid & win_ready; on issue edge dp_feature/dp_weight SHALL load win_feature/win_weight, else hold.
REQ-008 win_ready SHALL be high only in RUN, when issued < latched win_count and (inflight + fifo_count) < FIFO_DEPTH (credit rule; no result ever dropped).
REQ-009 A tag shift register of PIPE_LAT+1 stages SHALL track issues; a window issued at edge t SHALL have dp_result written into the FIFO at edge t+PIPE_LAT+1.
REQ-010 RUN SHALL go to DRAIN on the edge issuing the last window.
REQ-011 DRAIN SHALL go to DONE on the edge the last result pops (res_valid & res_ready & res_last).
REQ-012 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-013 busy SHALL be 1 in RUN and DRAIN, 0 otherwise.
REQ-014 res_valid SHALL equal FIFO non-empty; res_data SHALL be the FIFO head, first-word-fall-through; res_data/res_valid SHALL be held while res_valid & !res_ready.
REQ-015 res_last SHALL be 1 only with the head entry that is the job's win_count-th result.
REQ-016 Simultaneous FIFO push and pop SHALL both take effect, occupancy unchanged; when full, push cannot occur by REQ-008.
REQ-017 inflight SHALL count tags set in the shift register; issue and capture on the same edge SHALL leave it unchanged.
REQ-018 Counters SHALL not wrap: win_count up to 2^CNT_WIDTH-1 SHALL complete correctly.

Reset
REQ-019 RST=1 at an edge SHALL force IDLE, clear counters, tags and FIFO, and set busy=0, done=0, win_ready=0, res_valid=0, res_last=0, res_data=0, dp_feature=0, dp_weight=0, dp_bias=0, dp_scale=0, dp_shift=0.
REQ-020 RST mid-job SHALL abandon all in-flight results; first post-reset start SHALL behave as from power-up.

Configuration
REQ-021 With macro CNN_SCHED_PERF_EN defined, port perf_stall, out, 32, SHALL count cycles in RUN with win_valid=1 and win_ready=0, cleared on RST and on job start, saturating at 2^32-1.
REQ-022 Without CNN_SCHED_PERF_EN, port perf_stall and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-023 win_count=4, win_valid=1 and res_ready=1 constant -> 4 issues on consecutive edges; res_valid first high after PIPE_LAT+1 edges from first issue; res_last on 4th; done 1 cycle after last pop.
REQ-024 win_count=40, res_ready=0 -> win_ready drops after exactly FIFO_DEPTH=16 issues, no result lost; release res_ready -> all 40 results in order, matching golden model.
REQ-025 start with win_count=0 -> done pulses next cycle, busy never 1, no res_valid.
REQ-026 start pulsed again during RUN with different cfg_bias -> ignored, dp_bias unchanged until job ends.
REQ-027 RST asserted 3 cycles into 8-window job -> all outputs 0 next cycle; new 2-window job yields exactly 2 results.
REQ-028 CNN_SCHED_PERF_EN defined, win_count=20, res_ready=0 with win_valid held high for 30 RUN cycles -> perf_stall=14.
